// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and default sizing for the DDR3 memory request arbiter.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 23;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Width needed to hold a requester index; a lone requester still gets one bit
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_grant.sv
// Combinational round-robin picker: first active request strictly after the
// pointer, wrapping around, reported as one-hot, as an index and as an any-flag.
module rr_grant
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idxWidth(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Walk the candidates ptr+1 .. ptr+NUM_REQ (mod NUM_REQ) and keep the first hit,
    // so the requester served last has the lowest priority next time
    always_comb begin
        int cand;
        cand    = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(i_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!o_any && i_req[cand]) begin
                o_any         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the single DDR3 controller port between several requesters.
// One transaction in flight, round-robin grant, req/ack handshake per requester,
// traffic held off until the controller is calibrated, and a completion watchdog.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      i_clk,
    input  logic                      i_sys_reset,
    input  logic                      i_mem_ready,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_ctl_rd,
    output logic                      o_ctl_wr,
    output logic [ADDR_W-1:0]         o_ctl_addr,
    output logic [DATA_W-1:0]         o_ctl_din,
    input  logic                      i_ctl_busy,
    input  logic [DATA_W-1:0]         i_ctl_dout,
    input  logic                      i_ctl_dout_valid,
    output logic                      o_timeout_err
);

    localparam int              IDX_W   = idxWidth(NUM_REQ);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    // Counter value seen during the TIMEOUT-th WAIT cycle (count starts at zero)
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t          r_state;
    arb_state_t          w_nextState;

    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_prePtr;
    logic [IDX_W-1:0]    r_grantIdx;
    logic                r_we;
    logic [ADDR_W-1:0]   r_ctlAddr;
    logic [DATA_W-1:0]   r_ctlDin;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_timeoutErr;
    logic [WD_W-1:0]     r_wdCnt;

    logic [NUM_REQ-1:0]  w_grantOh;
    logic [IDX_W-1:0]    w_grantIdx;
    logic                w_anyReq;
    logic                w_selWe;
    logic [ADDR_W-1:0]   w_selAddr;
    logic [DATA_W-1:0]   w_selWdata;

    logic                w_grantFire;
    logic                w_abort;
    logic                w_complete;
    logic                w_rdCapture;
    logic                w_timeoutHit;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rrGrant (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grantOh),
        .o_idx   (w_grantIdx),
        .o_any   (w_anyReq)
    );

    // Route the winning requester's direction, address and write data toward the latches
    always_comb begin
        w_selWe    = 1'b0;
        w_selAddr  = '0;
        w_selWdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grantOh[i]) begin
                w_selWe    = i_we[i];
                w_selAddr  = i_addr[i*ADDR_W +: ADDR_W];
                w_selWdata = i_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_sys_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the single-cycle events that steer the datapath
    always_comb begin
        w_nextState  = r_state;
        w_grantFire  = 1'b0;
        w_abort      = 1'b0;
        w_complete   = 1'b0;
        w_rdCapture  = 1'b0;
        w_timeoutHit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mem_ready && !i_ctl_busy && w_anyReq) begin
                    w_grantFire = 1'b1;
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i_mem_ready) begin
                    w_abort     = 1'b1;
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_mem_ready) begin
                    w_abort     = 1'b1;
                    w_nextState = ST_IDLE;
                end else if (!r_we && i_ctl_dout_valid) begin
                    // Data arriving on the last watchdog cycle still counts as success
                    w_rdCapture = 1'b1;
                    w_complete  = 1'b1;
                    w_nextState = ST_DONE;
                end else if (r_we && !i_ctl_busy && (r_wdCnt != '0)) begin
                    // A nonzero count means the strobe was at least two cycles ago,
                    // so the controller has had time to raise busy for this write
                    w_complete  = 1'b1;
                    w_nextState = ST_DONE;
                end else if (r_wdCnt == WD_LAST) begin
                    w_timeoutHit = 1'b1;
                    w_complete   = 1'b1;
                    w_nextState  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Command latches, round-robin pointer with abort rollback, watchdog and completion pulses
    always_ff @(posedge i_clk) begin
        if (i_sys_reset) begin
            r_ptr        <= '0;
            r_prePtr     <= '0;
            r_grantIdx   <= '0;
            r_we         <= 1'b0;
            r_ctlAddr    <= '0;
            r_ctlDin     <= '0;
            r_rdata      <= '0;
            r_ack        <= '0;
            r_timeoutErr <= 1'b0;
            r_wdCnt      <= '0;
        end else begin
            r_ack        <= '0;
            r_timeoutErr <= 1'b0;

            if (w_grantFire) begin
                r_grantIdx <= w_grantIdx;
                r_we       <= w_selWe;
                r_ctlAddr  <= w_selAddr;
                r_ctlDin   <= w_selWdata;
                r_prePtr   <= r_ptr;
                r_ptr      <= w_grantIdx;
            end

            if (r_state == ST_ISSUE) begin
                r_wdCnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wdCnt <= r_wdCnt + 1'b1;
            end

            if (w_abort) begin
                r_ptr <= r_prePtr;
            end

            if (w_rdCapture) begin
                r_rdata <= i_ctl_dout;
            end

            if (w_timeoutHit) begin
                r_timeoutErr <= 1'b1;
                if (!r_we) begin
                    r_rdata <= '0;
                end
            end

            if (w_complete) begin
                r_ack <= NUM_REQ'(1) << r_grantIdx;
            end
        end
    end

    assign o_ctl_rd      = (r_state == ST_ISSUE) && i_mem_ready && !r_we;
    assign o_ctl_wr      = (r_state == ST_ISSUE) && i_mem_ready &&  r_we;
    assign o_ctl_addr    = r_ctlAddr;
    assign o_ctl_din     = r_ctlDin;
    assign o_ack         = r_ack;
    assign o_rdata       = r_rdata;
    assign o_timeout_err = r_timeoutErr;

    // Handshake sanity: at most one requester acknowledged, never both command strobes
    assert property (@(posedge i_clk) disable iff (i_sys_reset) $onehot0(o_ack));
    assert property (@(posedge i_clk) disable iff (i_sys_reset) !(o_ctl_rd && o_ctl_wr));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of grant order and completion timing.
module tb_mem_req_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 64;

    logic                      clk = 1'b0;
    logic                      sysReset;
    logic                      memReady;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [ADDR_W-1:0]         addrArr [NUM_REQ];
    logic [DATA_W-1:0]         wdataArr [NUM_REQ];
    logic [NUM_REQ*ADDR_W-1:0] addrBus;
    logic [NUM_REQ*DATA_W-1:0] wdataBus;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      ctlRd;
    logic                      ctlWr;
    logic [ADDR_W-1:0]         ctlAddr;
    logic [DATA_W-1:0]         ctlDin;
    logic                      ctlBusy;
    logic [DATA_W-1:0]         ctlDout;
    logic                      ctlDoutValid;
    logic                      timeoutErr;

    int compared   = 0;
    int mismatched = 0;

    // Model state: last served requester and the rdata value that should be held
    int                modelPtr   = 0;
    logic [DATA_W-1:0] modelRdata = '0;

    // Observations from the most recent transaction
    bit                obsGotAck;
    logic [NUM_REQ-1:0] obsAck;
    int                obsStrobes;
    bit                obsWr;
    logic [ADDR_W-1:0] obsAddr;
    logic [DATA_W-1:0] obsDin;
    int                obsOff;
    logic [DATA_W-1:0] obsRdata;
    int                obsToCnt;
    bit                obsBoth;
    bit                obsMulti;

    always #5 clk = ~clk;

    assign addrBus  = {addrArr[2], addrArr[1], addrArr[0]};
    assign wdataBus = {wdataArr[2], wdataArr[1], wdataArr[0]};

    mem_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk            (clk),
        .i_sys_reset      (sysReset),
        .i_mem_ready      (memReady),
        .i_req            (req),
        .i_we             (we),
        .i_addr           (addrBus),
        .i_wdata          (wdataBus),
        .o_ack            (ack),
        .o_rdata          (rdata),
        .o_ctl_rd         (ctlRd),
        .o_ctl_wr         (ctlWr),
        .o_ctl_addr       (ctlAddr),
        .o_ctl_din        (ctlDin),
        .i_ctl_busy       (ctlBusy),
        .i_ctl_dout       (ctlDout),
        .i_ctl_dout_valid (ctlDoutValid),
        .o_timeout_err    (timeoutErr)
    );

    // One clock: inputs change 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester after ptr, wrapping
    function automatic int predict(input int ptr, input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic applyStimulus_reset();
        sysReset     = 1'b1;
        memReady     = 1'b0;
        req          = '0;
        ctlBusy      = 1'b0;
        ctlDoutValid = 1'b0;
        repeat (3) cyc();
        sysReset     = 1'b0;
        modelPtr     = 0;
        modelRdata   = '0;
    endtask

    // Plays the controller for one transaction and records what the arbiter did.
    // rdLat: cycles after the strobe that dout_valid pulses (0 = never).
    // busyLen: cycles after the strobe that busy stays high.
    task automatic run_txn(input int rdLat, input int busyLen, input logic [DATA_W-1:0] dout,
                           input bit dropOnAck, input bit dropAtStrobe);
        int rel;
        rel        = -1;
        obsGotAck  = 1'b0;
        obsAck     = '0;
        obsStrobes = 0;
        obsWr      = 1'b0;
        obsAddr    = '0;
        obsDin     = '0;
        obsOff     = -1;
        obsRdata   = '0;
        obsToCnt   = 0;
        obsBoth    = 1'b0;
        obsMulti   = 1'b0;
        for (int c = 0; c < 200 && !obsGotAck; c++) begin
            cyc();
            if (rel >= 0) rel++;
            ctlDoutValid = (rel >= 1) && (rdLat > 0) && (rel == rdLat);
            ctlDout      = ctlDoutValid ? dout : DATA_W'($urandom);
            ctlBusy      = (rel >= 1) && (rel <= busyLen);
            #1;
            if (ctlRd && ctlWr) obsBoth = 1'b1;
            if (ctlRd || ctlWr) begin
                obsStrobes++;
                if (rel < 0) begin
                    rel     = 0;
                    obsWr   = ctlWr;
                    obsAddr = ctlAddr;
                    obsDin  = ctlDin;
                    if (dropAtStrobe) req = '0;
                end
            end
            if (timeoutErr) obsToCnt++;
            if (ack != '0) begin
                if (!$onehot(ack)) obsMulti = 1'b1;
                obsGotAck = 1'b1;
                obsAck    = ack;
                obsOff    = rel;
                obsRdata  = rdata;
                if (dropOnAck) req = req & ~ack;
            end
        end
        ctlDoutValid = 1'b0;
        ctlBusy      = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        sysReset     = 1'b1;
        memReady     = 1'b0;
        req          = '0;
        we           = '0;
        ctlBusy      = 1'b0;
        ctlDoutValid = 1'b0;
        ctlDout      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addrArr[i]  = '0;
            wdataArr[i] = '0;
        end
        repeat (3) cyc();
        #1;
        compared++;
        if (ack !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_ack: got %b want 000", ack); end
        compared++;
        if (rdata !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0000", rdata); end
        compared++;
        if ({ctlRd, ctlWr, timeoutErr} !== 3'b000) begin
            mismatched++; $display("[TB] FAIL reset_strobes: got rd=%b wr=%b to=%b want 0", ctlRd, ctlWr, timeoutErr);
        end
        compared++;
        if ({ctlAddr, ctlDin} !== 39'h0) begin
            mismatched++; $display("[TB] FAIL reset_cmd: got addr=%h din=%h want 0", ctlAddr, ctlDin);
        end
        sysReset   = 1'b0;
        modelPtr   = 0;
        modelRdata = '0;
        // Controller not calibrated: all requests must be held off
        req = 3'b111;
        we  = 3'b010;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            #1;
            if (ctlRd || ctlWr || ack != '0) bad++;
        end
        compared++;
        if (bad !== 0) begin mismatched++; $display("[TB] FAIL not_ready_hold: got %0d active cycles want 0", bad); end
        req      = '0;
        memReady = 1'b1;
        cyc();
    endtask

    task automatic test_single_read();
        we         = 3'b000;
        addrArr[1] = 23'h1234;
        req        = 3'b010;
        run_txn(2, 0, 16'hBEEF, 1'b1, 1'b0);
        modelPtr   = 1;
        modelRdata = 16'hBEEF;
        compared++;
        if (obsAck !== 3'b010) begin mismatched++; $display("[TB] FAIL single_ack: got %b want 010", obsAck); end
        compared++;
        if (obsAddr !== 23'h1234) begin mismatched++; $display("[TB] FAIL single_addr: got %h want 1234", obsAddr); end
        compared++;
        if (obsOff !== 3) begin mismatched++; $display("[TB] FAIL single_latency: got %0d want 3", obsOff); end
        compared++;
        if (obsRdata !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL single_rdata: got %h want beef", obsRdata); end
        compared++;
        if (obsStrobes !== 1 || obsWr !== 1'b0) begin
            mismatched++; $display("[TB] FAIL single_strobe: got %0d strobes wr=%b want 1 read", obsStrobes, obsWr);
        end
        cyc();
        #1;
        compared++;
        if (ack !== 3'b000 || rdata !== 16'hBEEF) begin
            mismatched++; $display("[TB] FAIL single_after: got ack=%b rdata=%h want 000/beef", ack, rdata);
        end
    endtask

    task automatic test_rr_order();
        int               order [6] = '{1, 2, 0, 1, 2, 0};
        logic [DATA_W-1:0] dout;
        applyStimulus_reset();
        memReady   = 1'b1;
        we         = 3'b000;
        addrArr[0] = 23'h000100;
        addrArr[1] = 23'h000200;
        addrArr[2] = 23'h000300;
        req        = 3'b111;
        for (int i = 0; i < 6; i++) begin
            dout = DATA_W'($urandom);
            run_txn(1 + $urandom_range(0, 3), 0, dout, 1'b0, 1'b0);
            if (i == 5) req = '0;
            compared++;
            if (obsAck !== 3'(1 << order[i])) begin
                mismatched++; $display("[TB] FAIL rr_order[%0d]: got %b want idx %0d", i, obsAck, order[i]);
            end
            compared++;
            if (obsAddr !== addrArr[order[i]] || obsRdata !== dout) begin
                mismatched++; $display("[TB] FAIL rr_data[%0d]: got addr=%h rdata=%h want %h/%h", i, obsAddr, obsRdata, addrArr[order[i]], dout);
            end
            compared++;
            if (obsMulti || obsBoth || obsStrobes !== 1) begin
                mismatched++; $display("[TB] FAIL rr_protocol[%0d]: got multi=%b both=%b strobes=%0d want 0/0/1", i, obsMulti, obsBoth, obsStrobes);
            end
            modelPtr   = order[i];
            modelRdata = dout;
        end
    endtask

    task automatic test_write_busy();
        addrArr[2]  = 23'h2ABCD;
        wdataArr[2] = 16'h5A5A;
        we          = 3'b100;
        req         = 3'b100;
        // A stray read-data strobe during the write must be ignored
        run_txn(3, 5, 16'hDEAD, 1'b1, 1'b0);
        modelPtr = 2;
        compared++;
        if (obsWr !== 1'b1 || obsStrobes !== 1) begin
            mismatched++; $display("[TB] FAIL write_strobe: got wr=%b strobes=%0d want 1/1", obsWr, obsStrobes);
        end
        compared++;
        if (obsDin !== 16'h5A5A || obsAddr !== 23'h2ABCD) begin
            mismatched++; $display("[TB] FAIL write_cmd: got din=%h addr=%h want 5a5a/2abcd", obsDin, obsAddr);
        end
        compared++;
        if (obsAck !== 3'b100 || obsOff !== 7) begin
            mismatched++; $display("[TB] FAIL write_ack: got %b at +%0d want 100 at +7", obsAck, obsOff);
        end
        compared++;
        if (obsRdata !== modelRdata) begin
            mismatched++; $display("[TB] FAIL write_rdata_hold: got %h want %h", obsRdata, modelRdata);
        end
        we = '0;
    endtask

    task automatic test_timeout();
        int exp;
        we  = 3'b000;
        req = 3'b001;
        exp = predict(modelPtr, req);
        run_txn(0, 0, 16'h0, 1'b1, 1'b0);
        modelPtr   = exp;
        modelRdata = '0;
        compared++;
        if (obsAck !== 3'b001 || obsOff !== TIMEOUT + 1) begin
            mismatched++; $display("[TB] FAIL timeout_ack: got %b at +%0d want 001 at +%0d", obsAck, obsOff, TIMEOUT + 1);
        end
        compared++;
        if (obsToCnt !== 1) begin mismatched++; $display("[TB] FAIL timeout_err: got %0d pulses want 1", obsToCnt); end
        compared++;
        if (obsRdata !== 16'h0) begin mismatched++; $display("[TB] FAIL timeout_rdata: got %h want 0000", obsRdata); end
        // Data arriving in the very cycle the watchdog expires wins
        req = 3'b001;
        run_txn(TIMEOUT, 0, 16'h1357, 1'b1, 1'b0);
        modelRdata = 16'h1357;
        compared++;
        if (obsToCnt !== 0 || obsRdata !== 16'h1357 || obsOff !== TIMEOUT + 1) begin
            mismatched++; $display("[TB] FAIL timeout_edge: got to=%0d rdata=%h off=%0d want 0/1357/%0d", obsToCnt, obsRdata, obsOff, TIMEOUT + 1);
        end
    endtask

    task automatic test_mem_ready_drop();
        int  exp;
        int  bad;
        bit  seen;
        we         = 3'b000;
        addrArr[0] = 23'h0A000;
        addrArr[1] = 23'h0B000;
        addrArr[2] = 23'h0C000;
        req        = 3'b111;
        exp        = predict(modelPtr, req);
        seen       = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cyc();
            #1;
            if (ctlRd || ctlWr) seen = 1'b1;
        end
        compared++;
        if (!seen || ctlAddr !== addrArr[exp]) begin
            mismatched++; $display("[TB] FAIL drop_first_grant: got seen=%b addr=%h want 1/%h", seen, ctlAddr, addrArr[exp]);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            memReady     = 1'b0;
            ctlDoutValid = (i == 2);
            ctlDout      = 16'hDEAD;
            #1;
            if (ack != '0 || ctlRd || ctlWr || timeoutErr) bad++;
        end
        ctlDoutValid = 1'b0;
        memReady     = 1'b1;
        compared++;
        if (bad !== 0) begin mismatched++; $display("[TB] FAIL drop_quiet: got %0d active cycles want 0", bad); end
        run_txn(2, 0, 16'hC0DE, 1'b1, 1'b0);
        req        = '0;
        modelPtr   = exp;
        modelRdata = 16'hC0DE;
        compared++;
        if (obsAck !== 3'(1 << exp) || obsAddr !== addrArr[exp]) begin
            mismatched++; $display("[TB] FAIL drop_regrant: got %b addr=%h want idx %0d addr=%h", obsAck, obsAddr, exp, addrArr[exp]);
        end
        compared++;
        if (obsRdata !== 16'hC0DE) begin mismatched++; $display("[TB] FAIL drop_rdata: got %h want c0de", obsRdata); end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        int bad;
        we         = 3'b000;
        addrArr[1] = 23'h7FFFF;
        req        = 3'b010;
        seen       = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cyc();
            #1;
            if (ctlRd || ctlWr) seen = 1'b1;
        end
        cyc();
        sysReset     = 1'b1;
        ctlDoutValid = 1'b1;
        ctlDout      = 16'hFACE;
        cyc();
        sysReset     = 1'b0;
        ctlDoutValid = 1'b0;
        req          = '0;
        modelPtr     = 0;
        modelRdata   = '0;
        #1;
        compared++;
        if (ack !== 3'b000 || rdata !== 16'h0 || ctlAddr !== 23'h0 || ctlRd || ctlWr || timeoutErr) begin
            mismatched++; $display("[TB] FAIL midop_reset: got ack=%b rdata=%h addr=%h rd=%b wr=%b want all 0", ack, rdata, ctlAddr, ctlRd, ctlWr);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            if (ack != '0 || ctlRd || ctlWr) bad++;
        end
        compared++;
        if (!seen || bad !== 0) begin
            mismatched++; $display("[TB] FAIL midop_quiet: got seen=%b active=%0d want 1/0", seen, bad);
        end
    endtask

    task automatic test_random();
        int                exp;
        int                rdLat;
        int                busyLen;
        int                expOff;
        int                expTo;
        logic [DATA_W-1:0] expRd;
        logic [DATA_W-1:0] dout;
        bit                dropStrobe;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                addrArr[i]  = ADDR_W'($urandom);
                wdataArr[i] = DATA_W'($urandom);
            end
            we         = NUM_REQ'($urandom);
            req        = NUM_REQ'($urandom_range(1, 7));
            exp        = predict(modelPtr, req);
            rdLat      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            busyLen    = $urandom_range(0, 6);
            dout       = DATA_W'($urandom);
            dropStrobe = ($urandom_range(0, 3) == 0);
            run_txn(rdLat, busyLen, dout, 1'($urandom_range(0, 1)), dropStrobe);
            if (we[exp]) begin
                expOff = ((busyLen + 1 > 2) ? busyLen + 1 : 2) + 1;
                expTo  = 0;
                expRd  = modelRdata;
            end else if (rdLat >= 1 && rdLat <= TIMEOUT) begin
                expOff = rdLat + 1;
                expTo  = 0;
                expRd  = dout;
            end else begin
                expOff = TIMEOUT + 1;
                expTo  = 1;
                expRd  = '0;
            end
            compared++;
            if (obsAck !== 3'(1 << exp) || obsOff !== expOff) begin
                mismatched++; $display("[TB] FAIL rnd_ack[%0d]: got %b at +%0d want idx %0d at +%0d", it, obsAck, obsOff, exp, expOff);
            end
            compared++;
            if (obsAddr !== addrArr[exp] || obsDin !== wdataArr[exp] || obsWr !== we[exp]) begin
                mismatched++; $display("[TB] FAIL rnd_cmd[%0d]: got addr=%h din=%h wr=%b want %h/%h/%b", it, obsAddr, obsDin, obsWr, addrArr[exp], wdataArr[exp], we[exp]);
            end
            compared++;
            if (obsRdata !== expRd || obsToCnt !== expTo) begin
                mismatched++; $display("[TB] FAIL rnd_result[%0d]: got rdata=%h to=%0d want %h/%0d", it, obsRdata, obsToCnt, expRd, expTo);
            end
            compared++;
            if (obsMulti || obsBoth || obsStrobes !== 1) begin
                mismatched++; $display("[TB] FAIL rnd_protocol[%0d]: got multi=%b both=%b strobes=%0d want 0/0/1", it, obsMulti, obsBoth, obsStrobes);
            end
            modelPtr   = exp;
            modelRdata = expRd;
        end
        req = '0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_order();
        test_write_busy();
        test_timeout();
        test_mem_ready_drop();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
